// File: rtl/bw_pkg.sv
// Shared constants, FSM state enum and sample typedefs for the
// bandwidth edge-finder / interpolator blocks.
package bw_pkg;

    localparam int DEF_ACCUM_WIDTH    = 18;
    localparam int DEF_FREQ_BIN_WIDTH = 16;
    localparam int DEF_FRAC_BITS      = 8;
    localparam int DEF_THRESHOLD_DB   = 7680;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        DIVIDE,
        SCALE,
        DONE
    } interp_state_e;

    typedef logic signed [DEF_ACCUM_WIDTH-1:0] level_t;
    typedef logic signed [DEF_FREQ_BIN_WIDTH-1:0] freq_t;
    typedef logic signed [DEF_FREQ_BIN_WIDTH+DEF_FRAC_BITS-1:0] edge_t;

endpackage

// File: rtl/bw_edge_interp_if.sv
// Request/result bundle between an edge finder (master) and the
// crossing interpolator (slave).
interface bw_edge_interp_if
    import bw_pkg::*;
#(
    parameter int ACCUM_WIDTH    = DEF_ACCUM_WIDTH,
    parameter int FREQ_BIN_WIDTH = DEF_FREQ_BIN_WIDTH,
    parameter int FRAC_BITS      = DEF_FRAC_BITS
);

    logic                                       valid_i;
    logic                                       ready_o;
    logic signed [FREQ_BIN_WIDTH-1:0]           f1_i;
    logic signed [FREQ_BIN_WIDTH-1:0]           f2_i;
    logic signed [ACCUM_WIDTH-1:0]              L1_i;
    logic signed [ACCUM_WIDTH-1:0]              L2_i;
    logic signed [FREQ_BIN_WIDTH+FRAC_BITS-1:0] edge_o;
    logic                                       valid_o;
    logic                                       busy_o;
    logic                                       clamped_o;
    logic                                       degenerate_o;

    modport master (
        output valid_i, f1_i, f2_i, L1_i, L2_i,
        input  ready_o, edge_o, valid_o, busy_o, clamped_o, degenerate_o
    );

    modport slave (
        input  valid_i, f1_i, f2_i, L1_i, L2_i,
        output ready_o, edge_o, valid_o, busy_o, clamped_o, degenerate_o
    );

endinterface

// File: rtl/seq_div_unsigned.sv
// Restoring divider for dividend < divisor: produces QW fraction
// bits of dividend/divisor, one bit per cycle, MSB first.
module seq_div_unsigned #(
    parameter int W  = 19,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(QW + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  dsr_q;
    logic [QW-1:0] q_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic [W:0]    rem_sh;
    logic [W-1:0]  rem_sub;
    logic          take;

    // rem < divisor always holds, so the shifted value fits in W+1 bits
    // and the difference fits back in W bits.
    assign rem_sh   = {rem_q, 1'b0};
    assign take     = rem_sh >= {1'b0, dsr_q};
    assign rem_sub  = rem_sh[W-1:0] - dsr_q;
    assign done     = run_q && (cnt_q == CW'(QW - 1));
    assign quotient = q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            dsr_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= dividend;
            dsr_q <= divisor;
            q_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= take ? rem_sub : rem_sh[W-1:0];
            q_q   <= {q_q[QW-2:0], take};
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bw_edge_interp.sv
// Linear interpolation of the threshold crossing between two
// bracketing bins: edge = f1 + t*(f2-f1), t in [0,1] with FRAC_BITS bits.
module bw_edge_interp
    import bw_pkg::*;
#(
    parameter int ACCUM_WIDTH    = DEF_ACCUM_WIDTH,
    parameter int FREQ_BIN_WIDTH = DEF_FREQ_BIN_WIDTH,
    parameter int FRAC_BITS      = DEF_FRAC_BITS,
    parameter int THRESHOLD_DB   = DEF_THRESHOLD_DB
) (
    input logic              clk_i,
    input logic              rst_i,
    bw_edge_interp_if.slave  bus
);

    localparam int AW = ACCUM_WIDTH;
    localparam int FW = FREQ_BIN_WIDTH;
    localparam int FB = FRAC_BITS;
    localparam int EW = FW + FB;
    localparam logic [AW-1:0] THR = AW'(THRESHOLD_DB);

    interp_state_e state_q, state_d;

    logic [FW-1:0] f1_q, f2_q;
    logic [AW-1:0] l1_q, l2_q;
    logic [AW:0]   num, den, anum, aden;
    logic [FW:0]   df;
    logic [FB:0]   t_q, t_eff, setup_t;
    logic          clamp_q, degen_q, div_path_q;
    logic          setup_clamp, setup_degen, setup_div;
    logic          div_start, div_done;
    logic [FB-1:0] quot;
    logic [EW-1:0] base, t_ext, df_ext, edge_d, edge_q;
    logic          clamped_q, degenerate_q;

    assign num  = {THR[AW-1], THR} - {l1_q[AW-1], l1_q};
    assign den  = {l2_q[AW-1], l2_q} - {l1_q[AW-1], l1_q};
    assign anum = num[AW] ? -num : num;
    assign aden = den[AW] ? -den : den;
    assign df   = {f2_q[FW-1], f2_q} - {f1_q[FW-1], f1_q};

    always_comb begin
        setup_t     = '0;
        setup_clamp = 1'b0;
        setup_degen = 1'b0;
        setup_div   = 1'b0;
        if (den == '0) begin
            setup_degen = 1'b1;
        end else if (num == '0 || num[AW] != den[AW]) begin
            setup_clamp = (num != '0);
        end else if (anum >= aden) begin
            setup_t     = {1'b1, {FB{1'b0}}};
            setup_clamp = (anum != aden);
        end else begin
            setup_div = 1'b1;
        end
    end

    seq_div_unsigned #(
        .W  (AW + 1),
        .QW (FB)
    ) u_div (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (div_start),
        .dividend (anum),
        .divisor  (aden),
        .done     (div_done),
        .quotient (quot)
    );

    // Result always lies between the two bins, so the product and sum
    // can wrap modulo 2^EW without corrupting the final value.
    assign t_eff  = div_path_q ? {1'b0, quot} : t_q;
    assign base   = {f1_q, {FB{1'b0}}};
    assign t_ext  = {{(EW-FB-1){1'b0}}, t_eff};
    assign df_ext = {{(EW-FW-1){df[FW]}}, df};
    assign edge_d = base + t_ext * df_ext;

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE:   if (bus.valid_i) state_d = SETUP;
            SETUP: begin
                if (setup_div) begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end else begin
                    state_d = SCALE;
                end
            end
            DIVIDE: if (div_done) state_d = SCALE;
            SCALE:  state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            f1_q         <= '0;
            f2_q         <= '0;
            l1_q         <= '0;
            l2_q         <= '0;
            t_q          <= '0;
            clamp_q      <= 1'b0;
            degen_q      <= 1'b0;
            div_path_q   <= 1'b0;
            edge_q       <= '0;
            clamped_q    <= 1'b0;
            degenerate_q <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.valid_i) begin
                f1_q <= bus.f1_i;
                f2_q <= bus.f2_i;
                l1_q <= bus.L1_i;
                l2_q <= bus.L2_i;
            end
            if (state_q == SETUP) begin
                t_q        <= setup_t;
                clamp_q    <= setup_clamp;
                degen_q    <= setup_degen;
                div_path_q <= setup_div;
            end
            if (state_q == SCALE) begin
                edge_q       <= edge_d;
                clamped_q    <= clamp_q;
                degenerate_q <= degen_q;
            end
        end
    end

    assign bus.ready_o      = (state_q == IDLE);
    assign bus.valid_o      = (state_q == DONE);
    assign bus.busy_o       = (state_q == SETUP) || (state_q == DIVIDE) ||
                              (state_q == SCALE);
    assign bus.edge_o       = edge_q;
    assign bus.clamped_o    = clamped_q;
    assign bus.degenerate_o = degenerate_q;

endmodule

// File: tb/tb_bw_edge_interp.sv
// Self-checking bench for bw_edge_interp: vector table, random vectors
// against a reference model, back-to-back and mid-divide reset cases.
module tb_bw_edge_interp;

    localparam int AW = 18;
    localparam int FW = 16;
    localparam int FB = 8;

    typedef struct {
        int f1;
        int f2;
        int l1;
        int l2;
        int exp_edge;
        bit exp_cl;
        bit exp_dg;
        int exp_lat;
    } vec_t;

    typedef struct {
        int exp_edge;
        bit cl;
        bit dg;
        int lat;
        int acc;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_edge = 0;
    sb_t  sbq[$];
    sb_t  mon_e;
    vec_t tbl[12];

    bw_edge_interp_if bus ();

    bw_edge_interp dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic sb_t model(int f1, int f2, int l1, int l2);
        sb_t    m;
        longint num, den, an, ad, t;
        num = 7680 - longint'(l1);
        den = longint'(l2) - longint'(l1);
        an  = (num < 0) ? -num : num;
        ad  = (den < 0) ? -den : den;
        m.cl  = 1'b0;
        m.dg  = 1'b0;
        m.lat = 3;
        m.acc = 0;
        t     = 0;
        if (den == 0) begin
            m.dg = 1'b1;
        end else if (num == 0 || ((num < 0) != (den < 0))) begin
            m.cl = (num != 0);
        end else if (an >= ad) begin
            t    = 256;
            m.cl = (an != ad);
        end else begin
            t     = (an * 256) / ad;
            m.lat = 11;
        end
        m.exp_edge = int'(longint'(f1) * 256 + t * (longint'(f2) - longint'(f1)));
        return m;
    endfunction

    function automatic sb_t from_vec(vec_t v);
        sb_t e;
        e.exp_edge = v.exp_edge;
        e.cl       = v.exp_cl;
        e.dg       = v.exp_dg;
        e.lat      = v.exp_lat;
        e.acc      = 0;
        return e;
    endfunction

    task automatic drive(int f1, int f2, int l1, int l2);
        bus.f1_i = FW'(f1);
        bus.f2_i = FW'(f2);
        bus.L1_i = AW'(l1);
        bus.L2_i = AW'(l2);
    endtask

    // Call at a negedge; returns at the negedge after acceptance.
    task automatic send(int f1, int f2, int l1, int l2, sb_t e);
        bit ok = 1'b0;
        drive(f1, f2, l1, l2);
        bus.valid_i = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.ready_o) begin
                e.acc = cyc + 1;
                @(posedge clk);
                sbq.push_back(e);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        if (!ok) chk("accept timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain pending", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (bus.valid_o) begin
            chk("ready_o with valid_o", bus.ready_o, 0);
            if (sbq.size() == 0) begin
                chk("spurious valid_o", bus.valid_o, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("edge_o", longint'(bus.edge_o), mon_e.exp_edge);
                chk("clamped_o", bus.clamped_o, mon_e.cl);
                chk("degenerate_o", bus.degenerate_o, mon_e.dg);
                chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
                last_edge = mon_e.exp_edge;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sb_t e;
        int  f1, f2, l1, l2;
        int  accs[$];

        tbl[0]  = '{100, 101, 7424, 7936, 25728, 1'b0, 1'b0, 11};
        tbl[1]  = '{50, 49, 8192, 7168, 12672, 1'b0, 1'b0, 11};
        tbl[2]  = '{0, 1, 7679, 7682, 85, 1'b0, 1'b0, 11};
        tbl[3]  = '{20, 25, 7000, 7000, 5120, 1'b0, 1'b1, 3};
        tbl[4]  = '{20, 25, 7000, 7500, 6400, 1'b1, 1'b0, 3};
        tbl[5]  = '{20, 25, 8000, 9000, 5120, 1'b1, 1'b0, 3};
        tbl[6]  = '{30, 40, 7000, 7680, 10240, 1'b0, 1'b0, 3};
        tbl[7]  = '{30, 40, 7680, 8000, 7680, 1'b0, 1'b0, 3};
        tbl[8]  = '{-10, -12, 7424, 7936, -2816, 1'b0, 1'b0, 11};
        tbl[9]  = '{-32768, 32767, -131072, 131071, 458617, 1'b0, 1'b0, 11};
        tbl[10] = '{5, 3, 7690, 7600, 1224, 1'b0, 1'b0, 11};
        tbl[11] = '{7, 9, 7690, 7700, 1792, 1'b1, 1'b0, 3};

        bus.valid_i = 1'b0;
        drive(0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset edge_o", longint'(bus.edge_o), 0);
        chk("reset valid_o", bus.valid_o, 0);
        chk("reset busy_o", bus.busy_o, 0);
        chk("reset clamped_o", bus.clamped_o, 0);
        chk("reset degenerate_o", bus.degenerate_o, 0);
        chk("reset ready_o", bus.ready_o, 1);

        foreach (tbl[i]) begin
            send(tbl[i].f1, tbl[i].f2, tbl[i].l1, tbl[i].l2, from_vec(tbl[i]));
        end
        drain();

        for (int i = 0; i < 20; i++) begin
            f1 = int'($urandom_range(60000, 0)) - 30000;
            f2 = int'($urandom_range(60000, 0)) - 30000;
            if (i % 2 == 0) begin
                l1 = 7680 - int'($urandom_range(3000, 0));
                l2 = 7680 + int'($urandom_range(3000, 1));
                if (i % 4 == 0) begin
                    l1 = l1 + l2;
                    l2 = l1 - l2;
                    l1 = l1 - l2;
                end
            end else begin
                l1 = int'($urandom_range(262143, 0)) - 131072;
                l2 = int'($urandom_range(262143, 0)) - 131072;
            end
            send(f1, f2, l1, l2, model(f1, f2, l1, l2));
        end
        drain();

        // valid_i held high: one result per 12 cycles, no queuing
        drive(tbl[0].f1, tbl[0].f2, tbl[0].l1, tbl[0].l2);
        bus.valid_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) begin
                chk("busy_o mid-op", bus.busy_o, 1);
                chk("ready_o mid-op", bus.ready_o, 0);
            end
            if (bus.ready_o) begin
                e     = from_vec(tbl[0]);
                e.acc = cyc + 1;
                accs.push_back(e.acc);
                @(posedge clk);
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        chk("held-valid accepts", accs.size(), 3);
        if (accs.size() >= 2) chk("held-valid spacing", accs[1] - accs[0], 12);
        drain();
        repeat (3) @(negedge clk);
        chk("edge_o held", longint'(bus.edge_o), last_edge);

        // reset during the 4th DIVIDE cycle discards the operation
        send(tbl[1].f1, tbl[1].f2, tbl[1].l1, tbl[1].l2, from_vec(tbl[1]));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        chk("mid-op reset edge_o", longint'(bus.edge_o), 0);
        chk("mid-op reset valid_o", bus.valid_o, 0);
        chk("mid-op reset busy_o", bus.busy_o, 0);
        chk("mid-op reset clamped_o", bus.clamped_o, 0);
        chk("mid-op reset degenerate_o", bus.degenerate_o, 0);
        chk("mid-op reset ready_o", bus.ready_o, 1);
        send(tbl[2].f1, tbl[2].f2, tbl[2].l1, tbl[2].l2, from_vec(tbl[2]));
        drain();
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
